// File: rtl/bldc_pkg.sv
// Shared types and hall-code helpers for the BLDC run sequencer.
package bldc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_RUN   = 3'd2,
    ST_BRAKE = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam logic [2:0] FC_NONE         = 3'd0;
  localparam logic [2:0] FC_OVERCURRENT  = 3'd1;
  localparam logic [2:0] FC_HALL_INVALID = 3'd2;
  localparam logic [2:0] FC_SEQUENCE     = 3'd3;
  localparam logic [2:0] FC_STALL        = 3'd4;

  // Forward rotation order: 101 -> 100 -> 110 -> 010 -> 011 -> 001 -> 101.
  function automatic logic [2:0] hall_next_fwd(input logic [2:0] code);
    logic [2:0] nxt;
    case (code)
      3'b101:  nxt = 3'b100;
      3'b100:  nxt = 3'b110;
      3'b110:  nxt = 3'b010;
      3'b010:  nxt = 3'b011;
      3'b011:  nxt = 3'b001;
      3'b001:  nxt = 3'b101;
      default: nxt = 3'b000;
    endcase
    return nxt;
  endfunction

  function automatic logic hall_invalid(input logic [2:0] code);
    return (code == 3'b000) || (code == 3'b111);
  endfunction

endpackage

// File: rtl/bldc_run_sequencer_hall_filter.sv
// Hall input synchroniser and debounce filter; emits a one-cycle edge pulse
// together with the previously accepted code for adjacency checking.
module hall_filter #(
  parameter int DEBOUNCE = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] hall_raw,
  output logic [2:0] hall_filt,
  output logic [2:0] hall_prev,
  output logic       hall_edge
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE);
  localparam logic [CW-1:0] CNT_TAKE = CW'(DEBOUNCE - 1);

  logic [2:0]    sync1_r, sync2_r, cand_r, filt_r, prev_r;
  logic [CW-1:0] cnt_r;
  logic          edge_r;

  // Synchroniser, stability counter and acceptance of a stable new code.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
      cand_r  <= 3'b000;
      cnt_r   <= {CW{1'b0}};
      filt_r  <= 3'b000;
      prev_r  <= 3'b000;
      edge_r  <= 1'b0;
    end else begin
      sync1_r <= hall_raw;
      sync2_r <= sync1_r;
      edge_r  <= 1'b0;
      if (sync2_r != cand_r) begin
        // The differing sample is itself the first stable cycle.
        cand_r <= sync2_r;
        cnt_r  <= CW'(1);
      end else begin
        if (cnt_r != CNT_MAX) begin
          cnt_r <= cnt_r + CW'(1);
        end
        if ((cnt_r >= CNT_TAKE) && (cand_r != filt_r)) begin
          prev_r <= filt_r;
          filt_r <= cand_r;
          edge_r <= 1'b1;
        end
      end
    end
  end

  assign hall_filt = filt_r;
  assign hall_prev = prev_r;
  assign hall_edge = edge_r;

endmodule

// File: rtl/bldc_run_sequencer.sv
// Supervisory sequencer for six-step commutation: idle, align, run, brake and
// fault, with direction detection and hall-edge period measurement.
module bldc_run_sequencer
  import bldc_pkg::*;
#(
  parameter int DEBOUNCE     = 16,
  parameter int ALIGN_CYCLES = 1000,
  parameter int STALL_CYCLES = 100000,
  parameter int BRAKE_CYCLES = 5000,
  parameter int CNT_W        = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       hall_raw,
  input  logic             start,
  input  logic             stop,
  input  logic             fault_in,
  input  logic             clear_fault,
  output logic [2:0]       hall_filt,
  output logic             drive_en,
  output logic             comm_reset,
  output logic             brake,
  output logic             dir,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [2:0]       state_o,
  output logic [2:0]       fault_code
);

  localparam logic [CNT_W-1:0] ALIGN_LAST = CNT_W'(ALIGN_CYCLES - 1);
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BRAKE_LAST = CNT_W'(BRAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};

  logic [2:0]       hall_filt_s, hall_prev_s;
  logic             hall_edge_s;
  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] timer_r, timer_nxt_s, timer_inc_s;
  logic [CNT_W-1:0] period_r, period_nxt_s;
  logic             period_valid_r, period_valid_nxt_s;
  logic [2:0]       fault_code_r, fault_code_nxt_s;
  logic             dir_r, dir_nxt_s;
  logic             drive_en_r, brake_r, comm_reset_r;
  logic             hall_ok_s, prev_ok_s, step_fwd_s, step_rev_s, seq_err_s;

  hall_filter #(.DEBOUNCE(DEBOUNCE)) u_hall_filter (
    .clock     (clock),
    .reset     (reset),
    .hall_raw  (hall_raw),
    .hall_filt (hall_filt_s),
    .hall_prev (hall_prev_s),
    .hall_edge (hall_edge_s)
  );

  assign hall_ok_s   = !hall_invalid(hall_filt_s);
  assign prev_ok_s   = !hall_invalid(hall_prev_s);
  assign step_fwd_s  = hall_edge_s && hall_ok_s && prev_ok_s &&
                       (hall_next_fwd(hall_prev_s) == hall_filt_s);
  assign step_rev_s  = hall_edge_s && hall_ok_s && prev_ok_s &&
                       (hall_next_fwd(hall_filt_s) == hall_prev_s);
  assign seq_err_s   = hall_edge_s && hall_ok_s && prev_ok_s && !step_fwd_s && !step_rev_s;
  assign timer_inc_s = (timer_r == CNT_SAT) ? CNT_SAT : timer_r + CNT_W'(1);

  // Next-state, timer, period and fault-code decisions in priority order.
  always_comb begin
    state_nxt_s        = state_r;
    timer_nxt_s        = timer_inc_s;
    period_nxt_s       = period_r;
    period_valid_nxt_s = 1'b0;
    fault_code_nxt_s   = fault_code_r;
    if (step_fwd_s) begin
      dir_nxt_s = 1'b1;
    end else if (step_rev_s) begin
      dir_nxt_s = 1'b0;
    end else begin
      dir_nxt_s = dir_r;
    end
    case (state_r)
      ST_IDLE: begin
        if (fault_in) begin
          state_nxt_s      = ST_FAULT;
          fault_code_nxt_s = FC_OVERCURRENT;
        end else if (start && !stop && hall_ok_s) begin
          state_nxt_s = ST_ALIGN;
          timer_nxt_s = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ALIGN: begin
        if (fault_in) begin
          state_nxt_s      = ST_FAULT;
          fault_code_nxt_s = FC_OVERCURRENT;
        end else if (!hall_ok_s) begin
          state_nxt_s      = ST_FAULT;
          fault_code_nxt_s = FC_HALL_INVALID;
        end else if ((timer_r >= ALIGN_LAST) && !hall_edge_s) begin
          state_nxt_s      = ST_FAULT;
          fault_code_nxt_s = FC_STALL;
        end else if (stop) begin
          state_nxt_s = ST_BRAKE;
          timer_nxt_s = {CNT_W{1'b0}};
        end else if (hall_edge_s) begin
          state_nxt_s = ST_RUN;
          timer_nxt_s = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = ST_ALIGN;
        end
      end
      ST_RUN: begin
        if (fault_in) begin
          state_nxt_s      = ST_FAULT;
          fault_code_nxt_s = FC_OVERCURRENT;
        end else if (!hall_ok_s) begin
          state_nxt_s      = ST_FAULT;
          fault_code_nxt_s = FC_HALL_INVALID;
        end else if (seq_err_s) begin
          state_nxt_s      = ST_FAULT;
          fault_code_nxt_s = FC_SEQUENCE;
        end else if ((timer_r >= STALL_LAST) && !hall_edge_s) begin
          state_nxt_s      = ST_FAULT;
          fault_code_nxt_s = FC_STALL;
        end else if (stop) begin
          state_nxt_s = ST_BRAKE;
          timer_nxt_s = {CNT_W{1'b0}};
        end else if (hall_edge_s) begin
          period_nxt_s       = timer_inc_s;
          period_valid_nxt_s = 1'b1;
          timer_nxt_s        = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_BRAKE: begin
        if (fault_in) begin
          state_nxt_s      = ST_FAULT;
          fault_code_nxt_s = FC_OVERCURRENT;
        end else if (timer_r >= BRAKE_LAST) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BRAKE;
        end
      end
      ST_FAULT: begin
        if (clear_fault && !fault_in) begin
          state_nxt_s      = ST_IDLE;
          fault_code_nxt_s = FC_NONE;
        end else begin
          state_nxt_s = ST_FAULT;
        end
      end
      default: begin
        state_nxt_s      = ST_IDLE;
        fault_code_nxt_s = FC_NONE;
      end
    endcase
  end

  // State register; gate controls are registered from the next state so they
  // always match the state encoding seen on state_o.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      timer_r        <= {CNT_W{1'b0}};
      period_r       <= {CNT_W{1'b0}};
      period_valid_r <= 1'b0;
      fault_code_r   <= FC_NONE;
      dir_r          <= 1'b1;
      drive_en_r     <= 1'b0;
      brake_r        <= 1'b0;
      comm_reset_r   <= 1'b1;
    end else begin
      state_r        <= state_nxt_s;
      timer_r        <= timer_nxt_s;
      period_r       <= period_nxt_s;
      period_valid_r <= period_valid_nxt_s;
      fault_code_r   <= fault_code_nxt_s;
      dir_r          <= dir_nxt_s;
      drive_en_r     <= (state_nxt_s == ST_ALIGN) || (state_nxt_s == ST_RUN);
      brake_r        <= (state_nxt_s == ST_BRAKE);
      comm_reset_r   <= !((state_nxt_s == ST_ALIGN) || (state_nxt_s == ST_RUN));
    end
  end

  assign hall_filt    = hall_filt_s;
  assign drive_en     = drive_en_r;
  assign comm_reset   = comm_reset_r;
  assign brake        = brake_r;
  assign dir          = dir_r;
  assign period       = period_r;
  assign period_valid = period_valid_r;
  assign state_o      = state_r;
  assign fault_code   = fault_code_r;

endmodule

// File: tb/tb_bldc_run_sequencer.sv
// Randomised and directed bench for bldc_run_sequencer against a cycle-level
// behavioural model built from the hall-sequence and state rules.
module tb_bldc_run_sequencer;

  localparam int DEB  = 4;
  localparam int ALN  = 100;
  localparam int STL  = 200;
  localparam int BRK  = 50;
  localparam int CW   = 24;
  localparam int TMAX = (1 << CW) - 1;

  localparam int M_IDLE  = 0;
  localparam int M_ALIGN = 1;
  localparam int M_RUN   = 2;
  localparam int M_BRAKE = 3;
  localparam int M_FAULT = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [2:0]    hall_raw;
  logic          start, stop, fault_in, clear_fault;
  logic [2:0]    hall_filt;
  logic          drive_en, comm_reset, brake, dir;
  logic [CW-1:0] period;
  logic          period_valid;
  logic [2:0]    state_o;
  logic [2:0]    fault_code;

  always #5 clock = ~clock;

  bldc_run_sequencer #(
    .DEBOUNCE(DEB), .ALIGN_CYCLES(ALN), .STALL_CYCLES(STL),
    .BRAKE_CYCLES(BRK), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .hall_raw(hall_raw), .start(start),
    .stop(stop), .fault_in(fault_in), .clear_fault(clear_fault),
    .hall_filt(hall_filt), .drive_en(drive_en), .comm_reset(comm_reset),
    .brake(brake), .dir(dir), .period(period), .period_valid(period_valid),
    .state_o(state_o), .fault_code(fault_code)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check_value(input string tag, input int obs, input int exp);
    n_compared++;
    if (obs != exp) begin
      n_mismatched++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Rotation order in the forward direction; reverse is the same list backwards.
  int fwd_seq[6] = '{5, 4, 6, 2, 3, 1};

  function automatic int seq_pos(input int c);
    for (int i = 0; i < 6; i++) begin
      if (fwd_seq[i] == c) return i;
    end
    return -1;
  endfunction

  int m_q[$];
  int m_filt, m_prev, m_edge, m_st, m_timer, m_dir, m_period, m_pv, m_fc;

  task automatic model_reset();
    m_q.delete();
    repeat (DEB + 2) m_q.push_back(0);
    m_filt = 0; m_prev = 0; m_edge = 0; m_st = M_IDLE; m_timer = 0;
    m_dir = 1; m_period = 0; m_pv = 0; m_fc = 0;
  endtask

  // Predicts the effect of the coming clock edge given the current inputs.
  task automatic model_step();
    int  ip, ic, ns, nt, nper, npv, nfc, ndir;
    bit  valid, fwd, rev, serr, stable;
    if (reset) begin
      model_reset();
      return;
    end
    ip    = seq_pos(m_prev);
    ic    = seq_pos(m_filt);
    valid = (ic >= 0);
    fwd   = (m_edge != 0) && ip >= 0 && ic >= 0 && ic == (ip + 1) % 6;
    rev   = (m_edge != 0) && ip >= 0 && ic >= 0 && ic == (ip + 5) % 6;
    serr  = (m_edge != 0) && ip >= 0 && ic >= 0 && !fwd && !rev;
    ns = m_st; nt = (m_timer >= TMAX) ? TMAX : m_timer + 1;
    nper = m_period; npv = 0; nfc = m_fc; ndir = m_dir;
    if (fwd) ndir = 1;
    else if (rev) ndir = 0;
    case (m_st)
      M_IDLE: begin
        if (fault_in) begin ns = M_FAULT; nfc = 1; end
        else if (start && !stop && valid) begin ns = M_ALIGN; nt = 0; end
      end
      M_ALIGN: begin
        if (fault_in) begin ns = M_FAULT; nfc = 1; end
        else if (!valid) begin ns = M_FAULT; nfc = 2; end
        else if (m_timer >= ALN - 1 && m_edge == 0) begin ns = M_FAULT; nfc = 4; end
        else if (stop) begin ns = M_BRAKE; nt = 0; end
        else if (m_edge != 0) begin ns = M_RUN; nt = 0; end
      end
      M_RUN: begin
        if (fault_in) begin ns = M_FAULT; nfc = 1; end
        else if (!valid) begin ns = M_FAULT; nfc = 2; end
        else if (serr) begin ns = M_FAULT; nfc = 3; end
        else if (m_timer >= STL - 1 && m_edge == 0) begin ns = M_FAULT; nfc = 4; end
        else if (stop) begin ns = M_BRAKE; nt = 0; end
        else if (m_edge != 0) begin
          nper = (m_timer >= TMAX) ? TMAX : m_timer + 1;
          npv = 1; nt = 0;
        end
      end
      M_BRAKE: begin
        if (fault_in) begin ns = M_FAULT; nfc = 1; end
        else if (m_timer >= BRK - 1) ns = M_IDLE;
      end
      default: begin
        if (clear_fault && !fault_in) begin ns = M_IDLE; nfc = 0; end
      end
    endcase
    // Filter: accept a code once it has been seen DEB times in a row after
    // two synchroniser stages.
    m_q.push_back(int'(hall_raw));
    void'(m_q.pop_front());
    stable = 1'b1;
    for (int i = 1; i < DEB; i++) begin
      if (m_q[i] != m_q[0]) stable = 1'b0;
    end
    m_edge = 0;
    if (stable && m_q[0] != m_filt) begin
      m_prev = m_filt; m_filt = m_q[0]; m_edge = 1;
    end
    m_st = ns; m_timer = nt; m_period = nper; m_pv = npv; m_fc = nfc; m_dir = ndir;
  endtask

  task automatic compare_all();
    check_value("state_o", int'(state_o), m_st);
    check_value("hall_filt", int'(hall_filt), m_filt);
    check_value("drive_en", int'(drive_en), (m_st == M_ALIGN || m_st == M_RUN) ? 1 : 0);
    check_value("brake", int'(brake), (m_st == M_BRAKE) ? 1 : 0);
    check_value("comm_reset", int'(comm_reset), (m_st == M_ALIGN || m_st == M_RUN) ? 0 : 1);
    check_value("dir", int'(dir), m_dir);
    check_value("period", int'(period), m_period);
    check_value("period_valid", int'(period_valid), m_pv);
    check_value("fault_code", int'(fault_code), m_fc);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  int cur, hold, r;

  initial begin
    reset = 1'b1; hall_raw = 3'b000; start = 1'b0; stop = 1'b0;
    fault_in = 1'b0; clear_fault = 1'b0;
    model_reset();
    run(3);
    check_value("reset_comm_reset", int'(comm_reset), 1);
    check_value("reset_dir", int'(dir), 1);
    reset = 1'b0;

    // Start and run, then a 150-cycle hall step for the period.
    hall_raw = 3'b101; start = 1'b1;
    run(10);
    check_value("align_state", int'(state_o), 1);
    hall_raw = 3'b100;
    run(20);
    check_value("run_state", int'(state_o), 2);
    check_value("run_dir_fwd", int'(dir), 1);
    run(130);
    hall_raw = 3'b110;
    run(20);
    check_value("period_150", int'(period), 150);

    // Glitch rejection.
    hall_raw = 3'b010; run(3);
    hall_raw = 3'b110; run(10);
    check_value("glitch_held", int'(hall_filt), 6);
    hall_raw = 3'b010; run(10);
    check_value("glitch_accept", int'(hall_filt), 2);

    // Stall, then clear.
    run(210);
    check_value("stall_code", int'(fault_code), 4);
    start = 1'b0; clear_fault = 1'b1; run(1); clear_fault = 1'b0; run(2);
    check_value("stall_cleared", int'(state_o), 0);
    check_value("stall_code_clear", int'(fault_code), 0);

    // Reverse step, then sequence error.
    start = 1'b1; run(3);
    hall_raw = 3'b011; run(10);
    hall_raw = 3'b001; run(10);
    hall_raw = 3'b101; run(10);
    hall_raw = 3'b001; run(10);
    check_value("rev_dir", int'(dir), 0);
    check_value("rev_state", int'(state_o), 2);
    hall_raw = 3'b110; run(10);
    check_value("seq_code", int'(fault_code), 3);
    start = 1'b0; clear_fault = 1'b1; run(1); clear_fault = 1'b0; run(2);

    // Overcurrent beats stop; clear ignored while fault_in is high.
    start = 1'b1; run(3);
    hall_raw = 3'b010; run(10);
    fault_in = 1'b1; stop = 1'b1; run(1);
    check_value("oc_code", int'(fault_code), 1);
    clear_fault = 1'b1; run(3);
    check_value("oc_held", int'(state_o), 4);
    fault_in = 1'b0; stop = 1'b0; start = 1'b0; run(1);
    check_value("oc_cleared", int'(state_o), 0);
    clear_fault = 1'b0;

    // Stop and brake, then IDLE gating cases.
    start = 1'b1; run(3);
    hall_raw = 3'b011; run(10);
    stop = 1'b1; start = 1'b0; run(1);
    check_value("brake_on", int'(brake), 1);
    run(48);
    check_value("brake_hold", int'(state_o), 3);
    run(2);
    check_value("brake_done", int'(state_o), 0);
    start = 1'b1; run(5);
    check_value("start_stop_idle", int'(state_o), 0);
    stop = 1'b0; start = 1'b0; hall_raw = 3'b111; run(10);
    start = 1'b1; run(10);
    check_value("invalid_idle", int'(state_o), 0);

    // Reset while running.
    start = 1'b0; hall_raw = 3'b010; run(10);
    start = 1'b1; run(3);
    hall_raw = 3'b011; run(10);
    reset = 1'b1; run(1);
    check_value("midrun_reset_drive", int'(drive_en), 0);
    reset = 1'b0; start = 1'b0; run(3);

    // Alignment timeout.
    start = 1'b1; run(105);
    check_value("align_timeout", int'(fault_code), 4);
    start = 1'b0; clear_fault = 1'b1; run(1); clear_fault = 1'b0; run(2);

    // Randomised traffic.
    cur = 3; hold = 0;
    for (int k = 0; k < 4000; k++) begin
      if (hold == 0) begin
        r = $urandom_range(0, 9);
        if (r < 8 && seq_pos(cur) >= 0) begin
          cur = fwd_seq[(seq_pos(cur) + ((r < 4) ? 1 : 5)) % 6];
        end else if (r < 8) begin
          cur = fwd_seq[$urandom_range(0, 5)];
        end else begin
          cur = $urandom_range(0, 7);
        end
        hall_raw = cur[2:0];
        hold = ($urandom_range(0, 29) == 0) ? 230 : $urandom_range(1, 30);
      end else begin
        hold--;
      end
      start       = ($urandom_range(0, 9) < 7);
      stop        = ($urandom_range(0, 99) < 2);
      fault_in    = ($urandom_range(0, 199) == 0);
      clear_fault = ($urandom_range(0, 19) == 0);
      reset       = ($urandom_range(0, 999) == 0);
      cycle();
    end
    reset = 1'b0;
    run(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/bldc_run_sequencer.md
Name: bldc_run_sequencer

Overview:
Supervisory controller for the hall-driven six-step commutation block. It filters the raw hall inputs and sequences the motor through idle, alignment, run, braking and fault. It gates the commutation stage via drive_en, comm_reset and brake. It also reports direction, hall-edge period and fault cause to the speed loop and host logic.

Parameters:
DEBOUNCE, 16, consecutive stable cycles required to accept a new hall code
ALIGN_CYCLES, 1000, max cycles in ALIGN waiting for the first hall edge
STALL_CYCLES, 100000, max cycles in RUN between accepted hall edges
BRAKE_CYCLES, 5000, duration of the BRAKE state
CNT_W, 24, width of the timer and period counters; must hold all of the above

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
hall_raw  in  3  {halla,hallb,hallc}, asynchronous
start  in  1  level; request motor run
stop  in  1  level; request braked stop
fault_in  in  1  external overcurrent/driver fault, already synchronous
clear_fault  in  1  single-cycle pulse; acknowledge fault
hall_filt  out  3  debounced hall code, fed to the commutation block
drive_en  out  1  enables the high/low gate outputs of the commutation block
comm_reset  out  1  holds the commutation block in reset
brake  out  1  all low-side switches on
dir  out  1  1 = forward (101→100→110→010→011→001→101), 0 = reverse
period  out  CNT_W  cycles between the last two accepted edges in RUN
period_valid  out  1  one-cycle pulse when period updates
state_o  out  3  current state encoding
fault_code  out  3  0 none, 1 overcurrent, 2 hall invalid, 3 sequence error, 4 stall

Behaviour:
- Interface: reset is synchronous, active-high; clock is clock. All state updates on posedge clock.
- Reset values:
  - state = IDLE; hall_filt = 000; dir = 1; period = 0.
  - period_valid = 0; fault_code = 0; drive_en = 0; brake = 0; comm_reset = 1.
- Hall filter:
  - 2-FF synchroniser, then a candidate register and a stability counter.
  - Counter clears whenever the synced value differs from the candidate.
  - When the candidate has been stable DEBOUNCE cycles and differs from hall_filt, hall_filt takes the candidate. hall_edge pulses one cycle in the same cycle.
  - Latency from a raw change to hall_filt: 2 + DEBOUNCE cycles.
- Validity: hall_filt of 000 or 111 is invalid.
- Adjacency check:
  - An edge matching the forward successor sets dir = 1.
  - An edge matching the predecessor sets dir = 0.
  - Any other edge between two valid codes is a sequence error.
- States (Moore outputs decoded from the state register):
  - IDLE: drive_en 0, brake 0, comm_reset 1.
  - ALIGN and RUN: drive_en 1, brake 0, comm_reset 0.
  - BRAKE: drive_en 0, brake 1, comm_reset 1.
  - FAULT: drive_en 0, brake 0, comm_reset 1.
- Transitions:
  - Evaluated every cycle; priority is fault_in > hall invalid > sequence error > timeout > stop > start.
  - IDLE → ALIGN: start=1, stop=0, hall_filt valid. Timer clears.
  - ALIGN → RUN: first hall_edge to a valid code. Timer clears; no period update on this edge.
  - ALIGN → FAULT(4): timer reaches ALIGN_CYCLES−1 with no edge.
  - RUN → FAULT(4): timer reaches STALL_CYCLES−1. Timer clears on each edge.
  - ALIGN/RUN → BRAKE: stop=1. Timer clears.
  - BRAKE → IDLE: after BRAKE_CYCLES cycles.
  - Any state except FAULT → FAULT(1): fault_in=1.
  - ALIGN/RUN → FAULT(2): hall_filt invalid.
  - RUN → FAULT(3): sequence error.
  - FAULT → IDLE: clear_fault=1 and fault_in=0. fault_code clears to 0 on exit.
- fault_code:
  - Latched on FAULT entry; holds through FAULT.
  - A fault_in during FAULT does not overwrite it.
- Period measurement:
  - On each RUN hall_edge, period ← timer+1 and period_valid = 1 for one cycle.
  - The timer saturates at all-ones and never wraps.
- Simultaneity:
  - stop and start together in IDLE: remain IDLE.
  - hall_edge and timeout in the same cycle: the edge wins, timer clears.
  - clear_fault while fault_in=1: ignored.
- Reset mid-run: forces IDLE outputs on the next edge; no BRAKE phase.

Decomposition:
- Package bldc_pkg:
  - state encodings IDLE=0, ALIGN=1, RUN=2, BRAKE=3, FAULT=4;
  - fault codes;
  - forward hall successor table (six entries) and the invalid-code test.
- Sub-module hall_filter:
  - contains the synchroniser, debounce counter, hall_filt register and hall_edge pulse;
  - parameter DEBOUNCE.

Test Plan:
(All scenarios use DEBOUNCE=4, ALIGN_CYCLES=100, STALL_CYCLES=200, BRAKE_CYCLES=50.)
- Start and run: reset, hall_raw=101, start=1 → hall_filt=101 after 6 cycles; state ALIGN, drive_en=1, comm_reset=0. Step to 100 → RUN, dir=1. Step to 110 after 150 cycles → period_valid pulse, period≈150±1.
- Glitch rejection: in RUN at 100, pulse hall_raw=110 for 3 cycles → hall_filt stays 100, no edge. Then hold 110 for 6 cycles → hall_filt=110.
- Stall: in RUN, hold hall constant 200 cycles → FAULT, fault_code=4, drive_en=0. clear_fault → IDLE, fault_code=0.
- Sequence error and reverse: in RUN, 101→001 → dir=0, stays RUN. Then 001→110 → FAULT, fault_code=3.
- Overcurrent and precedence: in RUN, fault_in=1 with stop=1 in the same cycle → FAULT code 1, not BRAKE. clear_fault while fault_in=1 → stays FAULT.
- Stop and brake: in RUN, stop=1 → BRAKE, brake=1, comm_reset=1 for 50 cycles → IDLE. Then hall 111 in IDLE with start=1 → remains IDLE.
